// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: multicycle phase encodings, next-PC select codes and
// the HALT opcode. Imported by fetch_unit and next_pc_calc.
package fetch_unit_pkg;

  // Phase codes driven by the state sequencer. Codes 101..111 are unused.
  // Any unused code counts as a non-IF phase.
  typedef enum logic [2:0] {
    ST_IF  = 3'b000,
    ST_ID  = 3'b001,
    ST_EXE = 3'b010,
    ST_WB  = 3'b011,
    ST_MEM = 3'b100
  } state_e;

  // Next-PC source select codes.
  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_REG    = 2'b10,
    PCSRC_JUMP   = 2'b11
  } pc_src_e;

  localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// next_pc_calc: purely combinational next-PC mux and adders.
// Ports:
//   pc_src    [1:0]  next-PC select (see pc_src_e)
//   pc4       [31:0] latched PC+4
//   ext_imm   [31:0] sign-extended branch offset, in words
//   reg_a_hi  [29:0] RegA[31:2]; the low bits are forced to 00 for jr
//   ir_target [25:0] IR[25:0], the jump target field
//   next_pc   [31:0] selected next PC
// All arithmetic wraps modulo 2^32 with no overflow indication.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc4,
  input  logic [31:0] ext_imm,
  input  logic [29:0] reg_a_hi,
  input  logic [25:0] ir_target,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc4;
    case (pc_src)
      PCSRC_SEQ:    next_pc = pc4;
      PCSRC_BRANCH: next_pc = pc4 + (ext_imm << 2);
      PCSRC_REG:    next_pc = {reg_a_hi, 2'b00};
      PCSRC_JUMP:   next_pc = {pc4[31:28], ir_target, 2'b00};
      default:      next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, IR and PC+4 registers for a multicycle CPU.
// Ports:
//   CLK, RST   clock; synchronous active-high reset
//   State      current multicycle phase (IF=000 loads IR and PC4)
//   InsData    instruction memory data at address PC
//   PCWre      PC write enable, asserted in the final phase of an instruction
//   PCSrc      next-PC select: 00 PC+4, 01 branch, 10 jr, 11 jump
//   ExtImm     sign-extended immediate
//   RegA       rs data for jr
//   PC, IR, Op, PC4    fetch state; Op = IR[31:26]
//   Halted     sticky; set by HALT opcode at end of ID, freezes PC/PC4/IR
//   AlignErr   sticky; set when jr writes PC from a misaligned RegA
// Optional: define FETCH_INSN_COUNT_EN to add InsCount, a wrapping count of
// accepted PC writes.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  State,
  input  logic [31:0] InsData,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ExtImm,
  input  logic [31:0] RegA,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [5:0]  Op,
  output logic [31:0] PC4,
  output logic        Halted,
  output logic        AlignErr
`ifdef FETCH_INSN_COUNT_EN
  ,
  output logic [31:0] InsCount
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] ir_q, ir_d;
  logic        halted_q, halted_d;
  logic        align_err_q, align_err_d;
  logic [31:0] next_pc;
  logic        pc_we;
  logic        fetch_en;

  next_pc_calc u_next_pc_calc (
    .pc_src    (PCSrc),
    .pc4       (pc4_q),
    .ext_imm   (ExtImm),
    .reg_a_hi  (RegA[31:2]),
    .ir_target (ir_q[25:0]),
    .next_pc   (next_pc)
  );

  // While halted nothing in the fetch path may move.
  assign pc_we    = PCWre && !halted_q;
  assign fetch_en = (State == ST_IF) && !halted_q;

  always_comb begin
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    ir_d        = ir_q;
    halted_d    = halted_q;
    align_err_d = align_err_q;
    // next_pc uses the old PC4/IR, so an IF phase that coincides with a PC
    // write still redirects using the previous instruction's context.
    if (pc_we) begin
      pc_d = next_pc;
      if ((PCSrc == PCSRC_REG) && (RegA[1:0] != 2'b00)) begin
        align_err_d = 1'b1;
      end
    end
    if (fetch_en) begin
      ir_d  = InsData;
      pc4_d = pc_q + 32'd4;
    end
    if (!halted_q && (State == ST_ID) && (ir_q[31:26] == OP_HALT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q        <= RESET_PC;
      pc4_q       <= RESET_PC + 32'd4;
      ir_q        <= '0;
      halted_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      ir_q        <= ir_d;
      halted_q    <= halted_d;
      align_err_q <= align_err_d;
    end
  end

`ifdef FETCH_INSN_COUNT_EN
  logic [31:0] ins_count_q, ins_count_d;

  always_comb begin
    ins_count_d = ins_count_q;
    if (pc_we) ins_count_d = ins_count_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) ins_count_q <= '0;
    else     ins_count_q <= ins_count_d;
  end

  assign InsCount = ins_count_q;
`endif

  assign PC       = pc_q;
  assign PC4      = pc4_q;
  assign IR       = ir_q;
  assign Op       = ir_q[31:26];
  assign Halted   = halted_q;
  assign AlignErr = align_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed instruction sequences, an abstract model
// checked every cycle, plus literal checkpoints.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  State = 3'd0;
  logic [31:0] InsData = '0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'd0;
  logic [31:0] ExtImm = '0;
  logic [31:0] RegA = '0;
  logic [31:0] PC, IR, PC4;
  logic [5:0]  Op;
  logic        Halted, AlignErr;
`ifdef FETCH_INSN_COUNT_EN
  logic [31:0] InsCount;
`endif

  fetch_unit #(.RESET_PC(RPC)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .State    (State),
    .InsData  (InsData),
    .PCWre    (PCWre),
    .PCSrc    (PCSrc),
    .ExtImm   (ExtImm),
    .RegA     (RegA),
    .PC       (PC),
    .IR       (IR),
    .Op       (Op),
    .PC4      (PC4),
    .Halted   (Halted),
    .AlignErr (AlignErr)
`ifdef FETCH_INSN_COUNT_EN
    ,
    .InsCount (InsCount)
`endif
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: architectural view of fetch state, updated per clock edge.
  bit          model_valid = 1'b0;
  logic [31:0] m_pc, m_pc4, m_ir, m_cnt;
  bit          m_halt, m_align;
  logic [31:0] o_pc, o_pc4, o_ir, tgt;

  always @(posedge CLK) begin
    if (RST) begin
      m_pc = RPC; m_pc4 = RPC + 4; m_ir = 0;
      m_halt = 0; m_align = 0; m_cnt = 0;
      model_valid = 1'b1;
    end else if (model_valid && !m_halt) begin
      o_pc = m_pc; o_pc4 = m_pc4; o_ir = m_ir;
      if (PCWre) begin
        case (PCSrc)
          2'd0: tgt = o_pc4;
          2'd1: tgt = o_pc4 + ExtImm * 4;
          2'd2: begin
            tgt = RegA - (RegA % 4);
            if (RegA % 4 != 0) m_align = 1;
          end
          default: tgt = (o_pc4 & 32'hF000_0000) | ((o_ir & 32'h03FF_FFFF) * 4);
        endcase
        m_pc  = tgt;
        m_cnt = m_cnt + 1;
      end
      if (State == 3'd0) begin
        m_ir  = InsData;
        m_pc4 = o_pc + 4;
      end
      if (State == 3'd1 && (o_ir >> 26) == 32'h3F) m_halt = 1;
    end
  end

  // Compare process, away from the active edge.
  always @(negedge CLK) begin
    if (model_valid) begin
      chk("pc", PC, m_pc);
      chk("pc4", PC4, m_pc4);
      chk("ir", IR, m_ir);
      chk("op", {26'd0, Op}, m_ir >> 26);
      chk("halted", {31'd0, Halted}, {31'd0, m_halt});
      chk("align_err", {31'd0, AlignErr}, {31'd0, m_align});
`ifdef FETCH_INSN_COUNT_EN
      chk("ins_count", InsCount, m_cnt);
`endif
    end
  end

  // Driver: one clock cycle with the given inputs.
  task automatic step(input logic rst, input logic [2:0] st, input logic we,
                      input logic [1:0] src, input logic [31:0] ins,
                      input logic [31:0] ext, input logic [31:0] ra);
    RST = rst; State = st; PCWre = we; PCSrc = src;
    InsData = ins; ExtImm = ext; RegA = ra;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    // Reset
    step(1, 3'd2, 1, 2'd3, 32'hFFFF_FFFF, 32'h1, 32'h7);
    chk("rst_pc", PC, 32'h0);
    chk("rst_pc4", PC4, 32'h4);
    chk("rst_ir", IR, 32'h0);
    chk("rst_halt", {31'd0, Halted}, 32'h0);
    chk("rst_align", {31'd0, AlignErr}, 32'h0);

    // Sequential fetch
    step(0, 3'd0, 0, 2'd0, 32'h0000_0001, 0, 0);
    chk("if_ir", IR, 32'h0000_0001);
    chk("if_pc4", PC4, 32'h4);
    step(0, 3'd1, 1, 2'd0, 0, 0, 0);
    chk("seq_pc", PC, 32'h4);

    // Reach PC=8, then branch with negative offset
    step(0, 3'd0, 0, 2'd0, 32'h0000_0002, 0, 0);
    step(0, 3'd1, 1, 2'd0, 0, 0, 0);
    chk("pc8", PC, 32'h8);
    step(0, 3'd0, 0, 2'd0, 32'h1000_0000, 0, 0);
    step(0, 3'd2, 1, 2'd1, 0, 32'hFFFF_FFFE, 0);
    chk("branch_pc", PC, 32'h4);

    // Wrap from FFFF_FFFC to 0
    step(0, 3'd2, 1, 2'd2, 0, 0, 32'hFFFF_FFFC);
    chk("jr_top", PC, 32'hFFFF_FFFC);
    step(0, 3'd0, 0, 2'd0, 0, 0, 0);
    chk("wrap_pc4", PC4, 32'h0);
    step(0, 3'd3, 1, 2'd0, 0, 0, 0);
    chk("wrap_pc", PC, 32'h0);

    // Jump
    step(0, 3'd2, 1, 2'd2, 0, 0, 32'h1000_0000);
    step(0, 3'd0, 0, 2'd0, 32'h0800_0010, 0, 0);
    chk("jmp_pc4", PC4, 32'h1000_0004);
    step(0, 3'd1, 1, 2'd3, 0, 0, 0);
    chk("jump_pc", PC, 32'h1000_0040);

    // Misaligned jr
    step(0, 3'd2, 1, 2'd2, 0, 0, 32'h0000_0103);
    chk("jr_mis_pc", PC, 32'h0000_0100);
    chk("jr_mis_err", {31'd0, AlignErr}, 32'h1);
    step(0, 3'd2, 1, 2'd2, 0, 0, 32'h0000_000C);
    chk("pc12", PC, 32'hC);
    chk("err_sticky", {31'd0, AlignErr}, 32'h1);

    // IF and PC write on the same edge at PC=12
    step(0, 3'd0, 1, 2'd0, 32'hAAAA_0012, 0, 0);
    chk("sim_ir", IR, 32'hAAAA_0012);
    chk("sim_pc", PC, 32'h1000_0004);
    chk("sim_pc4", PC4, 32'h10);

    // Reset during EXE
    step(0, 3'd0, 0, 2'd0, 32'h5555_5555, 0, 0);
    step(1, 3'd2, 1, 2'd2, 32'h1, 0, 32'h3);
    chk("mid_rst_pc", PC, 32'h0);
    chk("mid_rst_pc4", PC4, 32'h4);
    chk("mid_rst_ir", IR, 32'h0);
    chk("mid_rst_err", {31'd0, AlignErr}, 32'h0);

    // Unused phase code is non-IF
    step(0, 3'd7, 0, 2'd0, 32'hDEAD_BEEF, 0, 0);
    chk("st7_ir", IR, 32'h0);

    // Three instructions then HALT
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd0, 0, 2'd0, 32'h0000_0000, 0, 0);
      step(0, 3'd2, 1, 2'd0, 0, 0, 0);
    end
    chk("three_pc", PC, 32'hC);
    step(0, 3'd0, 0, 2'd0, 32'hFC00_0000, 0, 0);
    chk("halt_op", {26'd0, Op}, 32'h3F);
    step(0, 3'd1, 0, 2'd0, 0, 0, 0);
    chk("halted", {31'd0, Halted}, 32'h1);
    step(0, 3'd0, 1, 2'd0, 32'h1234_5678, 0, 0);
    step(0, 3'd0, 1, 2'd2, 32'h1111_1111, 0, 32'h40);
    chk("halt_pc", PC, 32'hC);
    chk("halt_ir", IR, 32'hFC00_0000);
    chk("halt_pc4", PC4, 32'h10);
`ifdef FETCH_INSN_COUNT_EN
    chk("count3", InsCount, 32'h3);
`endif
    step(1, 3'd0, 0, 2'd0, 0, 0, 0);
    chk("unhalt_pc", PC, 32'h0);
    chk("unhalt", {31'd0, Halted}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
